// File: rtl/ultrasonido_scheduler_if.sv
// Connection between the sensor scheduler and the shared ranging core.
//   core_enable : scheduler -> core, high while a measurement is running
//   core_echo   : scheduler -> core, ECHO line of the selected sensor
//   core_trigg  : core -> scheduler, trigger pulse for the selected sensor
//   core_d      : core -> scheduler, measured distance in cm
//   core_done   : core -> scheduler, core_d is valid on this cycle
// master = scheduler side, slave = ranging core side.
interface ultrasonido_scheduler_if;
  logic       core_enable;
  logic       core_echo;
  logic       core_trigg;
  logic [7:0] core_d;
  logic       core_done;

  modport master (
    output core_enable, core_echo,
    input  core_trigg, core_d, core_done
  );

  modport slave (
    input  core_enable, core_echo,
    output core_trigg, core_d, core_done
  );
endinterface

// File: rtl/ultrasonido_scheduler.sv
// Round-robin scheduler that shares one ultrasonic ranging core between
// three sensors. Each turn runs one measurement (bounded by a timeout),
// then waits a fixed idle gap before moving to the next sensor.
// Ports:
//   clk, reset      : clock, asynchronous active-low reset
//   start           : level, 1 = keep scanning
//   echo_in/trig_out: sensor ECHO inputs / trigger outputs (3 sensors)
//   core            : ranging core connection (master modport)
//   dist0..dist2    : last distance per sensor (8'hFF after a timeout)
//   valid, tmo      : per-sensor "has a result" / "last turn timed out"
//   sel             : sensor currently owning the core
//   busy, new_data  : scan in progress / one-cycle result strobe
module ultrasonido_scheduler #(
  parameter int GAP_CYCLES     = 3000000,
  parameter int TIMEOUT_CYCLES = 1500000
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [2:0]                     echo_in,
  output logic [2:0]                     trig_out,
  ultrasonido_scheduler_if.master        core,
  output logic [7:0]                     dist0,
  output logic [7:0]                     dist1,
  output logic [7:0]                     dist2,
  output logic [2:0]                     valid,
  output logic [2:0]                     tmo,
  output logic [1:0]                     sel,
  output logic                           busy,
  output logic                           new_data
);

  // One counter serves both MEAS and GAP, so it must hold the larger limit.
  localparam int MAX_CYC = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, MEAS = 2'd1, GAP = 2'd2} state_t;

  state_t        state_r, state_next;
  logic [CW-1:0] cnt_r, cnt_next;
  logic [1:0]    sel_r, sel_next;
  logic [7:0]    dist0_r, dist1_r, dist2_r;
  logic [7:0]    dist0_next, dist1_next, dist2_next;
  logic [2:0]    valid_r, valid_next, tmo_r, tmo_next;
  logic          new_data_r, new_data_next;
  logic          core_enable_r, busy_r;
  logic [2:0]    sel_mask;
  logic          echo_sel;

  // One-hot mask of the selected sensor.
  always_comb begin
    sel_mask = 3'b000;
    case (sel_r)
      2'd0:    sel_mask = 3'b001;
      2'd1:    sel_mask = 3'b010;
      2'd2:    sel_mask = 3'b100;
      default: sel_mask = 3'b000;
    endcase
  end

  // Route the selected sensor to the core; unselected triggers stay low.
  always_comb begin
    trig_out = 3'b000;
    echo_sel = 1'b0;
    case (sel_r)
      2'd0:    begin trig_out = {2'b00, core.core_trigg};       echo_sel = echo_in[0]; end
      2'd1:    begin trig_out = {1'b0, core.core_trigg, 1'b0};  echo_sel = echo_in[1]; end
      2'd2:    begin trig_out = {core.core_trigg, 2'b00};       echo_sel = echo_in[2]; end
      default: begin trig_out = 3'b000;                          echo_sel = 1'b0;       end
    endcase
  end

  // Next-state and result update; core_done outside MEAS falls through unused.
  always_comb begin
    state_next    = state_r;
    cnt_next      = cnt_r;
    sel_next      = sel_r;
    dist0_next    = dist0_r;
    dist1_next    = dist1_r;
    dist2_next    = dist2_r;
    valid_next    = valid_r;
    tmo_next      = tmo_r;
    new_data_next = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_next = MEAS;
          cnt_next   = {CW{1'b0}};
        end else begin
          state_next = IDLE;
        end
      end
      MEAS: begin
        // core_done is tested first so it wins over a coinciding timeout.
        if (core.core_done || (cnt_r == TMO_LAST)) begin
          if (sel_mask[0]) begin dist0_next = core.core_done ? core.core_d : 8'hFF; end
          else begin dist0_next = dist0_r; end
          if (sel_mask[1]) begin dist1_next = core.core_done ? core.core_d : 8'hFF; end
          else begin dist1_next = dist1_r; end
          if (sel_mask[2]) begin dist2_next = core.core_done ? core.core_d : 8'hFF; end
          else begin dist2_next = dist2_r; end
          if (core.core_done) begin
            valid_next = valid_r | sel_mask;
            tmo_next   = tmo_r & ~sel_mask;
          end else begin
            tmo_next   = tmo_r | sel_mask;
          end
          new_data_next = 1'b1;
          state_next    = GAP;
          cnt_next      = {CW{1'b0}};
        end else begin
          cnt_next = cnt_r + CW'(1);
        end
      end
      GAP: begin
        if (cnt_r == GAP_LAST) begin
          sel_next   = (sel_r == 2'd2) ? 2'd0 : sel_r + 2'd1;
          state_next = start ? MEAS : IDLE;
          cnt_next   = {CW{1'b0}};
        end else begin
          cnt_next = cnt_r + CW'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = {CW{1'b0}};
        sel_next   = 2'd0;
      end
    endcase
  end

  // State and output registers; reset clears every result immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= IDLE;
      cnt_r         <= {CW{1'b0}};
      sel_r         <= 2'd0;
      dist0_r       <= 8'd0;
      dist1_r       <= 8'd0;
      dist2_r       <= 8'd0;
      valid_r       <= 3'b000;
      tmo_r         <= 3'b000;
      new_data_r    <= 1'b0;
      core_enable_r <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      state_r       <= state_next;
      cnt_r         <= cnt_next;
      sel_r         <= sel_next;
      dist0_r       <= dist0_next;
      dist1_r       <= dist1_next;
      dist2_r       <= dist2_next;
      valid_r       <= valid_next;
      tmo_r         <= tmo_next;
      new_data_r    <= new_data_next;
      core_enable_r <= (state_next == MEAS);
      busy_r        <= (state_next != IDLE);
    end
  end

  assign core.core_enable = core_enable_r;
  assign core.core_echo   = echo_sel;
  assign dist0            = dist0_r;
  assign dist1            = dist1_r;
  assign dist2            = dist2_r;
  assign valid            = valid_r;
  assign tmo              = tmo_r;
  assign sel              = sel_r;
  assign busy             = busy_r;
  assign new_data         = new_data_r;

endmodule

// File: tb/tb_ultrasonido_scheduler.sv
// Bench for ultrasonido_scheduler: plays the ranging core, picks response
// times and distances with $urandom, and predicts every result per sensor turn.
module tb_ultrasonido_scheduler;
  localparam int GAP = 100;
  localparam int TMO = 50;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [2:0] echo_in;
  logic [2:0] trig_out;
  logic [7:0] dist0, dist1, dist2;
  logic [2:0] valid, tmo;
  logic [1:0] sel;
  logic       busy, new_data;

  ultrasonido_scheduler_if core_if ();

  ultrasonido_scheduler #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .start(start), .echo_in(echo_in),
    .trig_out(trig_out), .core(core_if.master),
    .dist0(dist0), .dist1(dist1), .dist2(dist2),
    .valid(valid), .tmo(tmo), .sel(sel), .busy(busy), .new_data(new_data)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference: what each sensor's outputs should hold, and whose turn it is.
  logic [7:0] exp_dist [3];
  logic [2:0] exp_valid, exp_tmo;
  int         exp_sel;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] dist_of(input int i);
    case (i)
      0:       return dist0;
      1:       return dist1;
      default: return dist2;
    endcase
  endfunction

  task automatic check_results(input string tag);
    for (int i = 0; i < 3; i++) chk({tag, "_dist"}, 32'(dist_of(i)), 32'(exp_dist[i]));
    chk({tag, "_valid"}, 32'(valid), 32'(exp_valid));
    chk({tag, "_tmo"}, 32'(tmo), 32'(exp_tmo));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_dist0"}, 32'(dist0), 32'd0);
    chk({tag, "_dist1"}, 32'(dist1), 32'd0);
    chk({tag, "_dist2"}, 32'(dist2), 32'd0);
    chk({tag, "_valid"}, 32'(valid), 32'd0);
    chk({tag, "_tmo"}, 32'(tmo), 32'd0);
    chk({tag, "_sel"}, 32'(sel), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_new_data"}, 32'(new_data), 32'd0);
    chk({tag, "_enable"}, 32'(core_if.core_enable), 32'd0);
  endtask

  // One sensor turn. k = MEAS cycle on which core_done is raised (outside
  // 0..TMO-1 means never); start drops at MEAS cycle drop_at (-1 = never).
  task automatic run_meas(input int k, input logic [7:0] d, input int drop_at, input bit cont);
    int t, cyc, len_exp, s, gap_n, nd_n;
    logic [2:0] tv;
    logic [2:0] bitm;
    s = exp_sel;
    bitm = 3'b001 << s;
    t = 0;
    while (core_if.core_enable !== 1'b1 && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk("meas_start", 32'(core_if.core_enable), 32'd1);
    chk("meas_sel", 32'(sel), 32'(s));
    chk("meas_busy", 32'(busy), 32'd1);
    cyc = 0;
    while (cyc < 200) begin
      if (cyc == drop_at) start = 1'b0;
      core_if.core_done  = (cyc == k);
      core_if.core_d     = (cyc == k) ? d : 8'($urandom);
      echo_in            = 3'($urandom);
      core_if.core_trigg = 1'($urandom);
      #1;
      tv = 3'b000;
      tv[s] = core_if.core_trigg;
      chk("echo_route", 32'(core_if.core_echo), 32'(echo_in[s]));
      chk("trig_route", 32'(trig_out), 32'(tv));
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (core_if.core_enable !== 1'b1) break;
    end
    core_if.core_done = 1'b0;
    if (k >= 0 && k < TMO) begin
      len_exp     = k + 1;
      exp_dist[s] = d;
      exp_valid   = exp_valid | bitm;
      exp_tmo     = exp_tmo & ~bitm;
    end else begin
      len_exp     = TMO;
      exp_dist[s] = 8'hFF;
      exp_tmo     = exp_tmo | bitm;
    end
    chk("meas_len", 32'(cyc), 32'(len_exp));
    chk("new_data_set", 32'(new_data), 32'd1);
    chk("gap_busy", 32'(busy), 32'd1);
    chk("gap_sel", 32'(sel), 32'(s));
    check_results("result");
    // Gap: core_done is wiggled here and must be ignored.
    gap_n = 0;
    nd_n  = 0;
    while (busy === 1'b1 && core_if.core_enable !== 1'b1 && gap_n < 400) begin
      nd_n += int'(new_data);
      core_if.core_done = 1'($urandom);
      core_if.core_d    = 8'($urandom);
      @(posedge clk);
      @(negedge clk);
      gap_n++;
    end
    core_if.core_done = 1'b0;
    chk("gap_len", 32'(gap_n), 32'(GAP));
    chk("new_data_width", 32'(nd_n), 32'd1);
    exp_sel = (s + 1) % 3;
    chk("sel_next", 32'(sel), 32'(exp_sel));
    chk("busy_after", 32'(busy), 32'(cont));
    chk("enable_after", 32'(core_if.core_enable), 32'(cont));
    check_results("after_gap");
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    echo_in = 3'b000;
    core_if.core_trigg = 1'b0;
    core_if.core_d     = 8'd0;
    core_if.core_done  = 1'b0;
    for (int i = 0; i < 3; i++) exp_dist[i] = 8'd0;
    exp_valid = 3'b000;
    exp_tmo   = 3'b000;
    exp_sel   = 0;
    #5;
    check_all_zero("reset");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("idle_no_start");

    start = 1'b1;
    run_meas(20, 8'd47, -1, 1'b1);                         // sensor 0, done after 20
    run_meas(-1, 8'd0, -1, 1'b1);                          // sensor 1 timeout
    run_meas(TMO - 1, 8'h3C, -1, 1'b1);                    // sensor 2, done on timeout cycle
    run_meas(int'($urandom_range(0, 70)), 8'($urandom), -1, 1'b1);
    run_meas(int'($urandom_range(0, TMO - 1)), 8'($urandom), -1, 1'b1);
    run_meas(int'($urandom_range(0, 70)), 8'($urandom), -1, 1'b1);
    run_meas(int'($urandom_range(0, 70)), 8'($urandom), -1, 1'b1);
    run_meas(-1, 8'd0, -1, 1'b1);                          // sensor 1 timeout, valid kept
    run_meas(int'($urandom_range(10, 40)), 8'($urandom), 3, 1'b0); // start dropped
    repeat (5) @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_enable", 32'(core_if.core_enable), 32'd0);
    chk("idle_sel", 32'(sel), 32'd0);

    // Reset between edges while a result is pending.
    start = 1'b1;
    repeat (4) @(negedge clk);
    chk("pre_reset_enable", 32'(core_if.core_enable), 32'd1);
    core_if.core_done = 1'b1;
    core_if.core_d    = 8'd99;
    #3 reset = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(posedge clk);
    @(negedge clk);
    core_if.core_done = 1'b0;
    check_all_zero("held_reset");
    start = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("post_reset_idle");
    for (int i = 0; i < 3; i++) exp_dist[i] = 8'd0;
    exp_valid = 3'b000;
    exp_tmo   = 3'b000;
    exp_sel   = 0;
    start = 1'b1;
    run_meas(5, 8'h11, 2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout: simulation exceeded time limit");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end
endmodule

// File: doc/ultrasonido_scheduler.md
ULTRASONIDO_SCHEDULER -- requirements
Module: ultrasonido_scheduler

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 3000000, meaning idle cycles between measurements (60 ms at 50 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1500000, meaning max cycles waiting for core_done (30 ms).
REQ-003 SHALL have port clk  input  1  system clock, 50 MHz, all state on rising edge.
REQ-004 SHALL have port reset  input  1  one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port start  input  1  level; 1 = keep scanning sensors round-robin.
REQ-006 SHALL have port echo_in  input  3  ECHO lines of sensors 0..2.
REQ-007 SHALL have port trig_out  output  3  trigger lines of sensors 0..2.
REQ-008 SHALL have ports core_enable output 1, core_echo output 1, core_trigg input 1, core_d input 8, core_done input 1: connection to the shared ranging core.
REQ-009 SHALL have ports dist0, dist1, dist2  output  8 each  last distance per sensor, cm.
REQ-010 SHALL have ports valid output 3, tmo output 3, sel output 2, busy output 1, new_data output 1.

Function
REQ-011 SHALL implement states IDLE, MEAS, GAP in a single registered FSM.
REQ-012 SHALL route core_echo = echo_in[sel] and trig_out[sel] = core_trigg, other trig_out bits 0, combinationally.
REQ-013 SHALL move IDLE->MEAS on the first clk edge with start=1; core_enable=1 exactly while in MEAS.
REQ-014 SHALL, in MEAS, count cycles from 0 starting on entry, cleared on every state change.
REQ-015 SHALL, in MEAS on an edge with core_done=1: load dist[sel]<=core_d, set valid[sel], clear tmo[sel], pulse new_data one cycle, go to GAP.
REQ-016 SHALL, in MEAS when counter = TIMEOUT_CYCLES-1 and core_done=0: load dist[sel]<=8'hFF, set tmo[sel], leave valid[sel] unchanged, pulse new_data, go to GAP.
REQ-017 SHALL give core_done priority when done and timeout coincide on the same edge.
REQ-018 SHALL remain in GAP exactly GAP_CYCLES cycles with core_enable=0, then advance sel (0->1->2->0, value 3 never produced).
REQ-019 SHALL leave GAP to MEAS if start=1, else to IDLE, on the same edge sel advances.
REQ-020 SHALL ignore start=0 during MEAS/GAP: current measurement and gap always complete.
REQ-021 SHALL ignore core_done outside MEAS.
REQ-022 SHALL drive busy=1 in MEAS and GAP, 0 in IDLE.
REQ-023 SHALL size counters to hold max(GAP_CYCLES, TIMEOUT_CYCLES) without wrap.

Reset
REQ-024 SHALL, on reset=0 at any time incl. mid-MEAS, immediately force IDLE, sel=0, counter=0, core_enable=0, dist0..2=0, valid=0, tmo=0, new_data=0, busy=0.
REQ-025 SHALL resume only after reset=1 and a clk edge with start=1; no measurement result lost mid-reset is written.

Verification (GAP_CYCLES=100, TIMEOUT_CYCLES=50)
REQ-026 SHALL cover: start=1, model core returns core_done with core_d=47 after 20 cycles -> dist0=47, valid=001, new_data 1 cycle, core_enable low 100 cycles, sel=1.
REQ-027 SHALL cover: core_done never asserted for sensor 1 -> after 50 MEAS cycles dist1=8'hFF, tmo=010, valid[1] unchanged.
REQ-028 SHALL cover: core_done on timeout cycle 49 -> dist captured from core_d, tmo bit clear.
REQ-029 SHALL cover: three full rounds -> sel sequence 0,1,2,0,1,2,0; trig_out and core_echo follow sel only.
REQ-030 SHALL cover: start dropped mid-MEAS -> measurement and gap complete, then IDLE, busy=0, core_enable=0.
REQ-031 SHALL cover: reset=0 asserted mid-MEAS between edges -> outputs zero asynchronously, dist unchanged by pending core_done.
